// File: rtl/rs_fwd_pkg.sv
// Shared types and select helpers for the reservation-station operand capture stage.
package rs_fwd_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned MAX_SEL_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } fwd_state_e;

    // All-ones select code of the given width means "no bus selected".
    function automatic logic [MAX_SEL_W-1:0] sel_none(input int unsigned sel_w);
        sel_none = MAX_SEL_W'((32'd1 << sel_w) - 32'd1);
    endfunction

    // A select names a real bus only when it indexes below the bus count.
    function automatic logic sel_valid(input int unsigned sel, input int unsigned n_fu);
        sel_valid = (sel < n_fu);
    endfunction

endpackage

// File: rtl/rs_fwd_operand_mux.sv
// Combinational source resolution for a single operand, plus its select-error flag.
module rs_fwd_operand_mux
    import rs_fwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_WIDTH,
    parameter int unsigned N_FU       = 10,
    parameter int unsigned SEL_W      = $clog2(N_FU + 1)
) (
    input  logic [DATA_WIDTH-1:0]      old_data,
    input  logic [SEL_W-1:0]           fu_sel,
    input  logic [SEL_W-1:0]           fuu_sel,
    input  logic                       aux_en,
    input  logic [DATA_WIDTH-1:0]      aux_data,
    input  logic [N_FU*DATA_WIDTH-1:0] fu_bus,
    input  logic [N_FU*DATA_WIDTH-1:0] fuu_bus,
    output logic [DATA_WIDTH-1:0]      data_c,
    output logic                       err_c
);

    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(sel_none(SEL_W));

    logic                  fu_v;
    logic                  fuu_v;
    logic [DATA_WIDTH-1:0] fu_pick;
    logic [DATA_WIDTH-1:0] fuu_pick;

    assign fu_v  = sel_valid(32'(fu_sel), N_FU);
    assign fuu_v = sel_valid(32'(fuu_sel), N_FU);

    // Bus selection as an AND-OR mux so an out-of-range index never reads past the bus.
    always_comb begin
        fu_pick  = '0;
        fuu_pick = '0;
        for (int i = 0; i < int'(N_FU); i++) begin
            if (fu_sel == SEL_W'(i)) begin
                fu_pick = fu_bus[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (fuu_sel == SEL_W'(i)) begin
                fuu_pick = fuu_bus[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Priority resolution: aux inject, current bus, registered bus, register file.
    always_comb begin
        data_c = old_data;
        if (aux_en) begin
            data_c = aux_data;
        end else if (fu_v) begin
            data_c = fu_pick;
        end else if (fuu_v) begin
            data_c = fuu_pick;
        end
        err_c = (fu_v & fuu_v)
              | (~fu_v & (fu_sel != SEL_NONE))
              | (~fuu_v & (fuu_sel != SEL_NONE));
    end

endmodule

// File: rtl/rs_fwd_capture_multi.sv
// Operand capture stage: resolves N_OPS operands per entry and registers them,
// with a 1-deep skid buffer so a stalled beat keeps its one-cycle forwarded data.
module rs_fwd_capture_multi
    import rs_fwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ALU_WIDTH,
    parameter int unsigned N_FU       = 10,
    parameter int unsigned N_OPS      = 3,
    parameter int unsigned SEL_W      = $clog2(N_FU + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [N_OPS*DATA_WIDTH-1:0] old_data,
    input  logic [N_OPS*SEL_W-1:0]      fu_sel,
    input  logic [N_OPS*SEL_W-1:0]      fuu_sel,
    input  logic [N_OPS-1:0]            aux_en,
    input  logic [N_OPS*DATA_WIDTH-1:0] aux_data,
    input  logic [N_FU*DATA_WIDTH-1:0]  fu_bus,
    input  logic [N_FU*DATA_WIDTH-1:0]  fuu_bus,
    output logic [N_OPS*DATA_WIDTH-1:0] out_data,
    output logic                        out_vld,
    output logic [N_OPS-1:0]            sel_err,
    output logic                        hold_vld
);

    localparam int unsigned OPS_W = N_OPS * DATA_WIDTH;

    fwd_state_e       state;
    fwd_state_e       state_nxt;
    logic [OPS_W-1:0] res_data;
    logic [N_OPS-1:0] res_err;
    logic [OPS_W-1:0] hold_data;
    logic [N_OPS-1:0] hold_err;
    logic             accept;
    logic             out_upd;
    logic             out_vld_nxt;
    logic             out_load;
    logic             out_from_hold;
    logic             hold_load;

    // Per-operand resolution muxes.
    for (genvar g = 0; g < int'(N_OPS); g++) begin : g_op
        rs_fwd_operand_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .N_FU       (N_FU),
            .SEL_W      (SEL_W)
        ) u_mux (
            .old_data (old_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .fu_sel   (fu_sel[g*SEL_W +: SEL_W]),
            .fuu_sel  (fuu_sel[g*SEL_W +: SEL_W]),
            .aux_en   (aux_en[g]),
            .aux_data (aux_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .fu_bus   (fu_bus),
            .fuu_bus  (fuu_bus),
            .data_c   (res_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .err_c    (res_err[g])
        );
    end

    assign hold_vld = (state == HELD);
    assign in_rdy   = ~stall | ~hold_vld;
    assign accept   = in_vld & in_rdy;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: enter HELD when a beat lands under stall, leave once drained with nothing new.
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept && stall) state_nxt = HELD;
            HELD:    if (!stall && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Datapath controls: output register only moves when not stalled.
    always_comb begin
        out_upd       = 1'b0;
        out_vld_nxt   = 1'b0;
        out_load      = 1'b0;
        out_from_hold = 1'b0;
        hold_load     = 1'b0;
        case (state)
            EMPTY: begin
                hold_load = accept & stall;
                if (!stall) begin
                    out_upd     = 1'b1;
                    out_vld_nxt = accept;
                    out_load    = accept;
                end
            end
            HELD: begin
                if (!stall) begin
                    out_upd       = 1'b1;
                    out_vld_nxt   = 1'b1;
                    out_load      = 1'b1;
                    out_from_hold = 1'b1;
                    hold_load     = accept;
                end
            end
            default: ;
        endcase
    end

    // Skid buffer: resolved beat and its errors captured together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_data <= '0;
            hold_err  <= '0;
        end else if (hold_load) begin
            hold_data <= res_data;
            hold_err  <= res_err;
        end
    end

    // Output register toward execute.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data <= '0;
            sel_err  <= '0;
            out_vld  <= 1'b0;
        end else begin
            if (out_upd) begin
                out_vld <= out_vld_nxt;
            end
            if (out_load) begin
                out_data <= out_from_hold ? hold_data : res_data;
                sel_err  <= out_from_hold ? hold_err  : res_err;
            end
        end
    end

endmodule

// File: tb/tb_rs_fwd_capture_multi.sv
// Scoreboard bench for rs_fwd_capture_multi with directed vectors.
module tb_rs_fwd_capture_multi;

    localparam int unsigned DW    = 32;
    localparam int unsigned NFU   = 10;
    localparam int unsigned NOPS  = 3;
    localparam int unsigned SW    = 4;
    localparam logic [SW-1:0] NONE = 4'hF;

    typedef struct packed {
        logic [NOPS*DW-1:0] d;
        logic [NOPS-1:0]    e;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 stall;
    logic                 in_vld;
    logic                 in_rdy;
    logic [NOPS*DW-1:0]   old_data;
    logic [NOPS*SW-1:0]   fu_sel;
    logic [NOPS*SW-1:0]   fuu_sel;
    logic [NOPS-1:0]      aux_en;
    logic [NOPS*DW-1:0]   aux_data;
    logic [NFU*DW-1:0]    fu_bus;
    logic [NFU*DW-1:0]    fuu_bus;
    logic [NOPS*DW-1:0]   out_data;
    logic                 out_vld;
    logic [NOPS-1:0]      sel_err;
    logic                 hold_vld;

    logic [DW-1:0] fu_b  [NFU];
    logic [DW-1:0] fuu_b [NFU];

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   upd;

    rs_fwd_capture_multi #(
        .DATA_WIDTH (DW),
        .N_FU       (NFU),
        .N_OPS      (NOPS),
        .SEL_W      (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .old_data (old_data),
        .fu_sel   (fu_sel),
        .fuu_sel  (fuu_sel),
        .aux_en   (aux_en),
        .aux_data (aux_data),
        .fu_bus   (fu_bus),
        .fuu_bus  (fuu_bus),
        .out_data (out_data),
        .out_vld  (out_vld),
        .sel_err  (sel_err),
        .hold_vld (hold_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(NFU); i++) begin
            fu_bus[i*DW +: DW]  = fu_b[i];
            fuu_bus[i*DW +: DW] = fuu_b[i];
        end
    end

    task automatic chk(input string nm, input logic [NOPS*DW-1:0] act, input logic [NOPS*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: a new beat is presented when out_vld is high after a non-stalled edge.
    always @(posedge clk) begin
        upd = rst && !stall;
        #1;
        if (upd && out_vld) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %h err %b expected no beat", out_data, sel_err);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("beat_data", out_data, e.d);
                chk("beat_err", 96'(sel_err), 96'(e.e));
            end
        end
    end

    task automatic set_op(input int k, input logic ae, input logic [DW-1:0] ad,
                          input logic [SW-1:0] fs, input logic [SW-1:0] us, input logic [DW-1:0] od);
        aux_en[k]             = ae;
        aux_data[k*DW +: DW]  = ad;
        fu_sel[k*SW +: SW]    = fs;
        fuu_sel[k*SW +: SW]   = us;
        old_data[k*DW +: DW]  = od;
    endtask

    task automatic set_all(input logic ae, input logic [DW-1:0] ad,
                           input logic [SW-1:0] fs, input logic [SW-1:0] us, input logic [DW-1:0] od);
        for (int k = 0; k < int'(NOPS); k++) set_op(k, ae, ad, fs, us, od);
    endtask

    task automatic push(input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                        input logic [NOPS-1:0] e);
        exp_t x;
        x.d = {d2, d1, d0};
        x.e = e;
        q.push_back(x);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst    = 1'b0;
        stall  = 1'b0;
        in_vld = 1'b0;
        aux_en = '0;
        aux_data = '0;
        old_data = '0;
        fu_sel   = {NOPS{NONE}};
        fuu_sel  = {NOPS{NONE}};
        for (int i = 0; i < int'(NFU); i++) begin
            fu_b[i]  = 32'h100 + 32'(i);
            fuu_b[i] = 32'h200 + 32'(i);
        end
        repeat (2) step();

        // Reset state
        chk("rst_out_data", out_data, '0);
        chk("rst_out_vld", 96'(out_vld), 96'(0));
        chk("rst_sel_err", 96'(sel_err), 96'(0));
        chk("rst_hold_vld", 96'(hold_vld), 96'(0));

        // 1: register-file path
        set_all(1'b0, 32'h0, NONE, NONE, 32'h55);
        in_vld = 1'b1;
        push(32'h55, 32'h55, 32'h55, 3'b000);
        rst = 1'b1;
        step();

        // 2: current bus, then registered bus
        fu_b[3] = 32'hAB;
        set_all(1'b0, 32'h0, 4'd3, NONE, 32'h55);
        push(32'hAB, 32'hAB, 32'hAB, 3'b000);
        step();
        fuu_b[9] = 32'hCD;
        set_all(1'b0, 32'h0, NONE, 4'd9, 32'h55);
        push(32'hCD, 32'hCD, 32'hCD, 3'b000);
        step();

        // 3: aux priority, select conflict, out-of-range fall-through
        set_all(1'b1, 32'h1000, 4'd2, NONE, 32'h55);
        push(32'h1000, 32'h1000, 32'h1000, 3'b000);
        step();
        fu_b[1]  = 32'h11;
        fuu_b[4] = 32'h44;
        set_all(1'b0, 32'h0, 4'd1, 4'd4, 32'h55);
        push(32'h11, 32'h11, 32'h11, 3'b111);
        step();
        fuu_b[6] = 32'h66;
        set_op(0, 1'b0, 32'h0, 4'd12, NONE, 32'h55);
        set_op(1, 1'b0, 32'h0, 4'd12, 4'd6, 32'h55);
        set_op(2, 1'b0, 32'h0, NONE, NONE, 32'h55);
        push(32'h55, 32'h66, 32'h55, 3'b011);
        step();

        // Idle cycle drops out_vld
        in_vld = 1'b0;
        step();
        chk("idle_out_vld", 96'(out_vld), 96'(0));

        // 4: accept under stall, forwarded value must survive bus change
        fu_b[5] = 32'h77;
        set_all(1'b0, 32'h0, 4'd5, NONE, 32'h55);
        in_vld = 1'b1;
        stall  = 1'b1;
        push(32'h77, 32'h77, 32'h77, 3'b000);
        step();
        fu_b[5] = 32'h0;
        set_all(1'b0, 32'h0, NONE, NONE, 32'h31);
        for (int c = 0; c < 2; c++) begin
            chk("stall_hold_vld", 96'(hold_vld), 96'(1));
            chk("stall_in_rdy", 96'(in_rdy), 96'(0));
            chk("stall_out_data", out_data, {32'h55, 32'h66, 32'h55});
            chk("stall_out_vld", 96'(out_vld), 96'(0));
            step();
        end
        stall  = 1'b0;
        in_vld = 1'b0;
        step();
        chk("drain_hold_vld", 96'(hold_vld), 96'(0));

        // 5: new beat accepted while draining the held one
        fu_b[5] = 32'h88;
        set_all(1'b0, 32'h0, 4'd5, NONE, 32'h55);
        in_vld = 1'b1;
        stall  = 1'b1;
        push(32'h88, 32'h88, 32'h88, 3'b000);
        step();
        in_vld = 1'b0;
        step();
        fu_b[5] = 32'h0;
        stall  = 1'b0;
        in_vld = 1'b1;
        set_all(1'b0, 32'h0, NONE, NONE, 32'h99);
        #1;
        chk("held_unstall_in_rdy", 96'(in_rdy), 96'(1));
        push(32'h99, 32'h99, 32'h99, 3'b000);
        step();
        chk("chain_hold_vld_1", 96'(hold_vld), 96'(1));
        in_vld = 1'b0;
        step();
        chk("chain_hold_vld_0", 96'(hold_vld), 96'(0));

        // 6: async reset while HELD discards the held beat
        set_all(1'b0, 32'h0, NONE, NONE, 32'hEE);
        in_vld = 1'b1;
        stall  = 1'b1;
        step();
        chk("pre_rst_hold_vld", 96'(hold_vld), 96'(1));
        chk("pre_rst_out_vld", 96'(out_vld), 96'(1));
        #2;
        rst = 1'b0;
        #1;
        chk("async_out_data", out_data, '0);
        chk("async_out_vld", 96'(out_vld), 96'(0));
        chk("async_sel_err", 96'(sel_err), 96'(0));
        chk("async_hold_vld", 96'(hold_vld), 96'(0));
        step();
        rst    = 1'b1;
        stall  = 1'b0;
        in_vld = 1'b0;
        repeat (3) step();
        chk("post_rst_out_vld", 96'(out_vld), 96'(0));
        chk("post_rst_out_data", out_data, '0);

        chk("queue_empty", 96'(q.size()), 96'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
